// File: rtl/sram_row_streamer.sv
// Streams one row of a row/k-addressed SRAM onto a valid/ready bus.
// A credit count (FIFO occupancy plus reads in flight) keeps the output FIFO from overflowing.
module sram_row_streamer #(
  parameter int M          = 8,
  parameter int KMAX       = 1024,
  parameter int DATA_W     = 32,
  parameter int BYTE_W     = DATA_W / 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = (M > 1) ? $clog2(M) : 1,
  parameter int K_W        = (KMAX > 1) ? $clog2(KMAX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  row,
  input  logic [K_W:0]      klen,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              w_en,
  output logic              w_re,
  output logic              w_we,
  output logic [ROW_W-1:0]  w_row,
  output logic [K_W-1:0]    w_k,
  output logic [DATA_W-1:0] w_wdata,
  output logic [BYTE_W-1:0] w_wmask,
  input  logic [DATA_W-1:0] w_rdata,
  input  logic              w_rvalid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [K_W:0]       K_ONE   = 1;
  localparam logic [PTR_W-1:0]   PTR_ONE = 1;
  localparam logic [CNT_W-1:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ROW_W-1:0]  row_q;
  logic [K_W:0]      klen_q;
  logic [K_W:0]      k_cnt;
  logic [K_W:0]      beat_cnt;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic              legal, accept, issue_run, issue, issue_last, push, pop;
  logic [K_W-1:0]    issue_k;

  assign w_we    = 1'b0;
  assign w_wdata = '0;
  assign w_wmask = '0;

  assign m_valid = (fifo_count != '0);
  assign m_data  = fifo_mem[rd_ptr];
  assign m_last  = m_valid && (beat_cnt == klen_q - K_ONE);

  // The first read goes out on the accepting edge so data arrives two cycles after start.
  always_comb begin
    legal      = (int'(row) < M) && (klen != '0) && (int'(klen) <= KMAX);
    accept     = (state == IDLE) && start && legal;
    issue_run  = (state == RUN) && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
    issue      = accept || issue_run;
    issue_k    = accept ? '0 : k_cnt[K_W-1:0];
    issue_last = accept ? (klen == K_ONE) : (k_cnt == klen_q - K_ONE);
    push       = w_rvalid && (state != IDLE);
    pop        = m_valid && m_ready;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= w_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      w_en       <= 1'b0;
      w_re       <= 1'b0;
      w_row      <= '0;
      w_k        <= '0;
      row_q      <= '0;
      klen_q     <= '0;
      k_cnt      <= '0;
      beat_cnt   <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      w_en <= issue;
      w_re <= issue;

      if (issue) begin
        w_row <= accept ? row : row_q;
        w_k   <= issue_k;
        k_cnt <= {1'b0, issue_k} + K_ONE;
      end

      case ({issue, push})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: ;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: ;
      endcase

      if (accept)   beat_cnt <= '0;
      else if (pop) beat_cnt <= beat_cnt + K_ONE;

      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              row_q  <= row;
              klen_q <= klen;
              busy   <= 1'b1;
              state  <= issue_last ? DRAIN : RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue_run && issue_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_row_streamer.md
SRAM_ROW_STREAMER -- requirements
Module: sram_row_streamer

Interface
REQ-001 Parameter M, default 8, number of rows in the attached row/k SRAM.
REQ-002 Parameter KMAX, default 1024, words per row.
REQ-003 Parameter DATA_W, default 32, word width.
REQ-004 Parameter BYTE_W, default DATA_W/8, byte-mask width.
REQ-005 Parameter FIFO_DEPTH, default 4 (power of two, >=2), output buffer entries.
REQ-006 Parameters ROW_W = max(1,clog2(M)) and K_W = max(1,clog2(KMAX)), derived widths.
REQ-007 clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-high.
REQ-009 start  input  1  one-cycle request to stream one row.
REQ-010 row  input  ROW_W  row to stream, sampled with start.
REQ-011 klen  input  K_W+1  words to stream (legal 1..KMAX), sampled with start.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse after the last beat handshakes.
REQ-014 err  output  1  one-cycle pulse when start is rejected for illegal arguments.
REQ-015 w_en, w_re, w_we  output  1 each  SRAM controls; w_we tied 0.
REQ-016 w_row  output  ROW_W; w_k  output  K_W  SRAM address.
REQ-017 w_wdata  output  DATA_W; w_wmask  output  BYTE_W; both tied 0.
REQ-018 w_rdata  input  DATA_W; w_rvalid  input  1  SRAM read return.
REQ-019 m_valid  output  1; m_ready  input  1; m_data  output  DATA_W; m_last  output  1  downstream stream.

Function
REQ-020 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE: start with row<M and 1<=klen<=KMAX latches row/klen, clears k counter and beat counter, moves to RUN, busy=1 next cycle.
REQ-022 IDLE: start with row>=M, klen==0, or klen>KMAX pulses err next cycle, no SRAM access, stays IDLE.
REQ-023 start while busy is ignored (no err, no effect).
REQ-024 RUN: read issued (w_en=w_re=1, w_row=latched row, w_k=k counter) only when fifo_count + inflight < FIFO_DEPTH; k counter increments per issued read.
REQ-025 w_en and w_re are 0 whenever no read is issued; w_row/w_k hold last values.
REQ-026 inflight counts issued reads not yet returned; increments on issue, decrements on w_rvalid, both same cycle leave it unchanged.
REQ-027 Every w_rvalid pushes w_rdata into the FIFO; credit rule guarantees no overflow; any SRAM latency >=1 cycle is tolerated.
REQ-028 RUN -> DRAIN in the cycle after the read with k = klen-1 is issued.
REQ-029 Stream: m_valid = FIFO non-empty; m_data = FIFO head; beat transfers when m_valid && m_ready; m_data/m_last held stable while m_valid && !m_ready.
REQ-030 m_last = 1 exactly on the beat whose beat counter equals klen-1.
REQ-031 Same-cycle push and pop on a full or empty FIFO are both honoured; count unchanged.
REQ-032 DRAIN -> DONE when the m_last beat transfers; DONE pulses done=1 for one cycle, clears busy, returns to IDLE.
REQ-033 With m_ready held 1 and 1-cycle SRAM latency, one beat per cycle sustained; first m_valid 2 cycles after start, done at cycle klen+2 after start.
REQ-034 klen==KMAX: k counter reaches KMAX-1 without wrap; no address beyond row*KMAX+KMAX-1 is generated.

Reset
REQ-035 rst high asynchronously forces IDLE; busy, done, err, w_en, w_re, m_valid, m_last = 0; w_row, w_k, counters, inflight, FIFO pointers = 0.
REQ-036 rst mid-stream discards in-flight reads and FIFO contents; w_rvalid arriving after reset release while IDLE is dropped.

Verification
REQ-037 SRAM preloaded row 3 = k*16+3, start row=3 klen=5, m_ready=1 -> beats 3,19,35,51,67, m_last on 67, done one cycle later.
REQ-038 Same run with m_ready toggling 1/0 -> identical data order, no loss/duplication, reads stall when fifo_count+inflight=4.
REQ-039 start row=8 (M=8) or klen=0 or klen=1025 -> err pulse, w_en never asserted, busy stays 0.
REQ-040 start row=7 klen=1024 -> 1024 beats, last w_k=1023, m_last only on beat 1023.
REQ-041 rst asserted after 3 beats of klen=10 -> all outputs 0 immediately; new start row=0 klen=2 yields exactly 2 correct beats.
REQ-042 Second start during busy -> ignored, first transfer completes unchanged.
